// File: rtl/vec_sequencer_pkg.sv
// Shared codes for the vector command sequencer: funct3 classes, bus codes, FSM states.
// Optional VSETVL support is enabled with VEC_SEQUENCER_VSETVL_EN.
package vec_sequencer_pkg;

    localparam logic [2:0] F3_ALU_VV = 3'd0;
    localparam logic [2:0] F3_ALU_VI = 3'd1;
    localparam logic [2:0] F3_MUL    = 3'd2;
    localparam logic [2:0] F3_ACC    = 3'd3;
    localparam logic [2:0] F3_VSETVL = 3'd4;

    localparam logic [1:0] BUS_NONE = 2'b00;
    localparam logic [1:0] BUS_ALU  = 2'b01;
    localparam logic [1:0] BUS_MUL  = 2'b10;
    localparam logic [1:0] BUS_ACC  = 2'b11;

    localparam logic [31:0] ILLEGAL_RSP_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [5:0]  VLEN_MAX            = 6'd32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_ALU_VV = 3'd0,
        OP_ALU_VI = 3'd1,
        OP_MUL    = 3'd2,
        OP_ACC    = 3'd3,
        OP_VSET   = 3'd4,
        OP_ILL    = 3'd5
    } op_e;

    // Index of the final pass for a grouped ALU op (2^lmul passes, lmul <= 3).
    function automatic logic [2:0] last_pass(input logic [2:0] lmul);
        case (lmul)
            3'd0:    return 3'd0;
            3'd1:    return 3'd1;
            3'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/vec_cmd_decode.sv
// Combinational decode of function_id into op class, ALU mode and illegal flag.
// VSETVL is only a legal class when VEC_SEQUENCER_VSETVL_EN is defined.
module vec_cmd_decode
    import vec_sequencer_pkg::*;
(
    input  logic [9:0] function_id,
    input  logic [2:0] vset_lmul,
    output op_e        op,
    output logic [1:0] alu_mode,
    output logic       illegal
);

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_funct7;

    assign funct3        = function_id[2:0];
    assign funct7        = function_id[9:3];
    assign unused_funct7 = ^funct7[6:2];

`ifndef VEC_SEQUENCER_VSETVL_EN
    logic unused_lmul;
    assign unused_lmul = ^vset_lmul;
`endif

    always_comb begin
        op       = OP_ILL;
        alu_mode = 2'b00;
        case (funct3)
            F3_ALU_VV: begin
                op       = OP_ALU_VV;
                alu_mode = funct7[1:0];
            end
            F3_ALU_VI: begin
                op       = OP_ALU_VI;
                alu_mode = funct7[1:0];
            end
            F3_MUL: op = OP_MUL;
            F3_ACC: op = OP_ACC;
`ifdef VEC_SEQUENCER_VSETVL_EN
            // LMUL above 8 has no pass schedule, so it is rejected here.
            F3_VSETVL: if (vset_lmul <= 3'd3) op = OP_VSET;
`endif
            default: op = OP_ILL;
        endcase
    end

    assign illegal = (op == OP_ILL);

endmodule

// File: rtl/vec_sequencer.sv
// Vector command sequencer: accepts one command, runs ISSUE/WB passes, returns one response.
// Define VEC_SEQUENCER_VSETVL_EN to make vlmul/vlen programmable through VSETVL.
module vec_sequencer
    import vec_sequencer_pkg::*;
#(
    parameter int          NREG        = 32,
    parameter logic [31:0] ILLEGAL_RSP = ILLEGAL_RSP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [4:0]  reg_op0_sel,
    output logic [4:0]  reg_op1_sel,
    output logic [4:0]  reg_wb_sel,
    output logic        reg_load,
    output logic [1:0]  bus_sel,
    output logic [1:0]  alu_mode,
    output logic        alu_op1_sel,
    output logic [7:0]  alu_imm,
    output logic [2:0]  vlmul,
    output logic [5:0]  vlen,
    input  logic [7:0]  acc_in,
    output logic        busy
);

    // Register indices wrap around the file; NREG is expected to be a power of two.
    localparam logic [4:0] IDX_MASK = 5'(NREG - 1);

    state_e      state, state_next;
    op_e         dec_op, op_q;
    logic [1:0]  dec_mode, mode_q;
    logic        dec_illegal;
    logic [7:0]  imm_q;
    logic [4:0]  vd_q, vs0_q, vs1_q;
    logic [2:0]  pass_q, last_q;
    logic [31:0] payload_q;
    logic [5:0]  vlen_new;
    logic        accept, is_alu, unused_in;

    vec_cmd_decode u_decode (
        .function_id (cmd_payload_function_id),
        .vset_lmul   (cmd_payload_inputs_1[2:0]),
        .op          (dec_op),
        .alu_mode    (dec_mode),
        .illegal     (dec_illegal)
    );

    assign unused_in = ^cmd_payload_inputs_1[31:8];
    assign accept    = cmd_valid && cmd_ready;
    assign vlen_new  = (cmd_payload_inputs_0 > 32'd32) ? VLEN_MAX : cmd_payload_inputs_0[5:0];
    assign is_alu    = (op_q == OP_ALU_VV) || (op_q == OP_ALU_VI);

`ifdef VEC_SEQUENCER_VSETVL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vlmul <= 3'd0;
            vlen  <= VLEN_MAX;
        end else if (accept && dec_op == OP_VSET) begin
            vlmul <= cmd_payload_inputs_1[2:0];
            vlen  <= vlen_new;
        end
    end
`else
    assign vlmul = 3'd0;
    assign vlen  = VLEN_MAX;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = (dec_illegal || dec_op == OP_VSET) ? S_RESP : S_ISSUE;
            S_ISSUE: state_next = S_WB;
            S_WB:    state_next = (pass_q == last_q) ? S_RESP : S_ISSUE;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command is captured at accept so the requester may change its payload afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_ALU_VV;
            mode_q    <= 2'b00;
            imm_q     <= 8'h00;
            vd_q      <= 5'd0;
            vs0_q     <= 5'd0;
            vs1_q     <= 5'd0;
            pass_q    <= 3'd0;
            last_q    <= 3'd0;
            payload_q <= 32'h0;
        end else if (accept) begin
            op_q      <= dec_op;
            mode_q    <= dec_mode;
            imm_q     <= (dec_op == OP_ALU_VI) ? cmd_payload_inputs_1[7:0] : 8'h00;
            vd_q      <= cmd_payload_inputs_0[4:0];
            vs0_q     <= cmd_payload_inputs_0[9:5];
            vs1_q     <= cmd_payload_inputs_0[14:10];
            pass_q    <= 3'd0;
            last_q    <= (dec_op == OP_ALU_VV || dec_op == OP_ALU_VI) ? last_pass(vlmul) : 3'd0;
            payload_q <= dec_illegal        ? ILLEGAL_RSP :
                         (dec_op == OP_VSET) ? {26'b0, vlen_new} : 32'h0;
        end else if (state == S_WB) begin
            pass_q <= pass_q + 3'd1;
            if (op_q == OP_ACC) payload_q <= {24'b0, acc_in};
        end
    end

    always_comb begin
        reg_op0_sel = 5'd0;
        reg_op1_sel = 5'd0;
        reg_wb_sel  = 5'd0;
        reg_load    = 1'b0;
        bus_sel     = BUS_NONE;
        alu_mode    = 2'b00;
        alu_op1_sel = 1'b0;
        alu_imm     = 8'h00;
        if (state == S_ISSUE || state == S_WB) begin
            reg_op0_sel = (vs0_q + 5'(pass_q)) & IDX_MASK;
            reg_op1_sel = (vs1_q + 5'(pass_q)) & IDX_MASK;
            reg_wb_sel  = (vd_q + 5'(pass_q)) & IDX_MASK;
            if (is_alu) begin
                alu_mode    = mode_q;
                alu_op1_sel = (op_q == OP_ALU_VI);
                alu_imm     = imm_q;
            end
            if (state == S_WB) begin
                reg_load = 1'b1;
                case (op_q)
                    OP_MUL:  bus_sel = BUS_MUL;
                    OP_ACC:  bus_sel = BUS_ACC;
                    default: bus_sel = BUS_ALU;
                endcase
            end
        end
    end

    assign cmd_ready             = reset && (state == S_IDLE);
    assign busy                  = (state != S_IDLE);
    assign rsp_valid             = (state == S_RESP);
    assign rsp_payload_outputs_0 = rsp_valid ? payload_q : 32'h0;

endmodule

// File: tb/tb_vec_sequencer.sv
// Directed bench for vec_sequencer: per-cycle trace model plus hand-computed literal checks.
module tb_vec_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id = '0;
    logic [31:0] cmd_payload_inputs_0 = '0;
    logic [31:0] cmd_payload_inputs_1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_payload_outputs_0;
    logic [4:0]  reg_op0_sel, reg_op1_sel, reg_wb_sel;
    logic        reg_load;
    logic [1:0]  bus_sel, alu_mode;
    logic        alu_op1_sel;
    logic [7:0]  alu_imm;
    logic [2:0]  vlmul;
    logic [5:0]  vlen;
    logic [7:0]  acc_in = '0;
    logic        busy;

    always #5 clk = ~clk;

    vec_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .reg_op0_sel             (reg_op0_sel),
        .reg_op1_sel             (reg_op1_sel),
        .reg_wb_sel              (reg_wb_sel),
        .reg_load                (reg_load),
        .bus_sel                 (bus_sel),
        .alu_mode                (alu_mode),
        .alu_op1_sel             (alu_op1_sel),
        .alu_imm                 (alu_imm),
        .vlmul                   (vlmul),
        .vlen                    (vlen),
        .acc_in                  (acc_in),
        .busy                    (busy)
    );

`ifdef VEC_SEQUENCER_VSETVL_EN
    localparam bit VSET_EN = 1'b1;
`else
    localparam bit VSET_EN = 1'b0;
`endif

    typedef struct packed {
        logic        cr, bz, rv;
        logic [31:0] pl;
        logic [4:0]  o0, o1, wb;
        logic        ld;
        logic [1:0]  bus, mode;
        logic        s1;
        logic [7:0]  imm;
        logic [2:0]  lm;
        logic [5:0]  vl;
    } rec_t;

    rec_t        exp_q[$];
    int          n_chk = 0, n_pass = 0;
    bit          chk_en = 1'b0;
    int          cyc = 0, hs_cyc = 0, rsp_lat = -1, loads = 0, resp_cycles = 0;
    logic [4:0]  op0_log[$], op1_log[$], wb_log[$];
    logic [1:0]  bus_log[$];
    logic [31:0] last_payload = '0;
    logic [2:0]  m_vlmul = 3'd0;
    logic [5:0]  m_vlen = 6'd32;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic rec_t dut_rec();
        rec_t r;
        r.cr = cmd_ready;   r.bz = busy;        r.rv = rsp_valid;
        r.pl = rsp_payload_outputs_0;
        r.o0 = reg_op0_sel; r.o1 = reg_op1_sel; r.wb = reg_wb_sel;
        r.ld = reg_load;    r.bus = bus_sel;    r.mode = alu_mode;
        r.s1 = alu_op1_sel; r.imm = alu_imm;    r.lm = vlmul;   r.vl = vlen;
        return r;
    endfunction

    function automatic rec_t idle_rec();
        rec_t r = '0;
        r.cr = 1'b1;
        r.lm = m_vlmul;
        r.vl = m_vlen;
        return r;
    endfunction

    // Expected cycle-by-cycle outputs of one accepted command, from the command rules.
    task automatic model_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1,
                             input logic [7:0] acc, input int hold, output int k);
        logic [2:0]  f3;
        logic [31:0] pl;
        int          passes;
        rec_t        r;
        f3 = fid[2:0];
        pl = 32'h0;
        passes = 0;
        case (f3)
            3'd0, 3'd1: passes = 1 << m_vlmul;
            3'd2:       passes = 1;
            3'd3:       begin passes = 1; pl = {24'h0, acc}; end
            3'd4: begin
                if (VSET_EN && in1[2:0] <= 3'd3) begin
                    m_vlmul = in1[2:0];
                    m_vlen  = (in0 > 32) ? 6'd32 : in0[5:0];
                    pl      = {26'h0, m_vlen};
                end else pl = 32'hFFFF_FFFF;
            end
            default: pl = 32'hFFFF_FFFF;
        endcase
        for (int p = 0; p < passes; p++) begin
            r    = '0;
            r.bz = 1'b1;
            r.o0 = 5'((int'(in0[9:5]) + p) % 32);
            r.o1 = 5'((int'(in0[14:10]) + p) % 32);
            r.wb = 5'((int'(in0[4:0]) + p) % 32);
            r.lm = m_vlmul;
            r.vl = m_vlen;
            if (f3 <= 3'd1) begin
                r.mode = fid[4:3];
                r.s1   = (f3 == 3'd1);
                r.imm  = (f3 == 3'd1) ? in1[7:0] : 8'h00;
            end
            exp_q.push_back(r);
            r.ld  = 1'b1;
            r.bus = (f3 <= 3'd1) ? 2'b01 : (f3 == 3'd2) ? 2'b10 : 2'b11;
            exp_q.push_back(r);
        end
        for (int h = 0; h <= hold; h++) begin
            r    = '0;
            r.bz = 1'b1;
            r.rv = 1'b1;
            r.pl = pl;
            r.lm = m_vlmul;
            r.vl = m_vlen;
            exp_q.push_back(r);
        end
        k = 2 * passes;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rec_t e, a;
        if (chk_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
            a = dut_rec();
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL trace cyc %0d: got %h, expected %h", cyc, a, e);
            if (cmd_valid && cmd_ready) hs_cyc = cyc;
            if (busy && !rsp_valid && !reg_load) begin
                op0_log.push_back(reg_op0_sel);
                op1_log.push_back(reg_op1_sel);
            end
            if (reg_load) begin
                loads++;
                wb_log.push_back(reg_wb_sel);
                bus_log.push_back(bus_sel);
            end
            if (rsp_valid) begin
                if (rsp_lat < 0) rsp_lat = cyc - hs_cyc;
                resp_cycles++;
                last_payload = rsp_payload_outputs_0;
            end
        end
    end

    task automatic run_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1,
                           input logic [7:0] acc, input int hold, input bit early);
        int n, k;
        op0_log.delete(); op1_log.delete(); wb_log.delete(); bus_log.delete();
        loads = 0; rsp_lat = -1; resp_cycles = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0 = in0;
        cmd_payload_inputs_1 = in1;
        acc_in = acc;
        rsp_ready = early;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            rsp_ready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_payload_function_id = '1;
        cmd_payload_inputs_0 = '1;
        cmd_payload_inputs_1 = '1;
        model_cmd(fid, in0, in1, acc, hold, k);
        repeat (k + hold) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [4:0] exp_wb[4];
        repeat (2) @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_vlmul", vlmul, 0);
        check("rst_vlen", vlen, 32);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_cmd_ready", cmd_ready, 1);
        chk_en = 1'b1;

        // ALU vv mode 1, vd=3 vs0=2 vs1=1
        run_cmd(10'h008, 32'h0443, 32'h0, 8'h00, 0, 1'b0);
        check("t1_issue_op0", (op0_log.size() > 0) ? op0_log[0] : 5'h1F, 2);
        check("t1_issue_op1", (op1_log.size() > 0) ? op1_log[0] : 5'h1F, 1);
        check("t1_wb_sel", (wb_log.size() > 0) ? wb_log[0] : 5'h1F, 3);
        check("t1_bus", (bus_log.size() > 0) ? bus_log[0] : 2'b00, 1);
        check("t1_loads", loads, 1);
        check("t1_rsp_lat", rsp_lat, 3);
        check("t1_payload", last_payload, 0);

`ifdef VEC_SEQUENCER_VSETVL_EN
        run_cmd(10'h004, 32'd20, 32'd2, 8'h00, 0, 1'b0);
        check("t2_vset_payload", last_payload, 32'h14);
        check("t2_vlmul", vlmul, 2);
        run_cmd(10'h000, 32'd30, 32'h0, 8'h00, 0, 1'b0);
        exp_wb = '{5'd30, 5'd31, 5'd0, 5'd1};
        check("t2_loads", loads, 4);
        for (int i = 0; i < 4; i++)
            check("t2_wb_sel", (wb_log.size() > i) ? wb_log[i] : 5'h1F, exp_wb[i]);
        run_cmd(10'h004, 32'd100, 32'd1, 8'h00, 0, 1'b0);
        check("t2_vlen_clamp", last_payload, 32);
        run_cmd(10'h004, 32'd7, 32'd5, 8'h00, 0, 1'b0);
        check("t2_bad_lmul_payload", last_payload, 32'hFFFF_FFFF);
        check("t2_bad_lmul_keep", vlmul, 1);
`else
        run_cmd(10'h004, 32'd20, 32'd2, 8'h00, 0, 1'b0);
        check("t2_vset_illegal", last_payload, 32'hFFFF_FFFF);
        check("t2_vlmul_const", vlmul, 0);
        run_cmd(10'h000, 32'd30, 32'h0, 8'h00, 0, 1'b0);
        exp_wb[0] = 5'd30;
        check("t2_loads", loads, 1);
        check("t2_wb_sel", (wb_log.size() > 0) ? wb_log[0] : 5'h1F, exp_wb[0]);
`endif

        run_cmd(10'h003, 32'h0001, 32'h0, 8'h5A, 0, 1'b0);
        check("t3_acc_payload", last_payload, 32'h0000_005A);
        check("t3_acc_bus", (bus_log.size() > 0) ? bus_log[0] : 2'b00, 3);

        run_cmd(10'h006, 32'h1234, 32'h0, 8'h00, 0, 1'b0);
        check("t4_ill_loads", loads, 0);
        check("t4_ill_payload", last_payload, 32'hFFFF_FFFF);
        check("t4_ill_lat", rsp_lat, 1);

        run_cmd(10'h002, 32'h1234, 32'h0, 8'h00, 5, 1'b0);
        check("t5_resp_cycles", resp_cycles, 6);
        check("t5_mul_bus", (bus_log.size() > 0) ? bus_log[0] : 2'b00, 2);

        run_cmd(10'h009, 32'h0C61, 32'hA5, 8'h00, 0, 1'b1);
        check("t6_early_ready_resp", resp_cycles, 1);

`ifdef VEC_SEQUENCER_VSETVL_EN
        run_cmd(10'h004, 32'd32, 32'd2, 8'h00, 0, 1'b0);
`endif
        chk_en = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_payload_function_id = 10'h000;
        cmd_payload_inputs_0 = 32'd30;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        check("t7_in_wb", reg_load, 1);
        reset = 1'b0;
        #1;
        check("t7_async_load", reg_load, 0);
        check("t7_async_bus", bus_sel, 0);
        check("t7_async_wb_sel", reg_wb_sel, 0);
        check("t7_async_busy", busy, 0);
        check("t7_async_cmd_ready", cmd_ready, 0);
        check("t7_async_vlmul", vlmul, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t7_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m_vlmul = 3'd0;
        m_vlen = 6'd32;
        exp_q.delete();
        @(negedge clk);
        check("t7_rel_cmd_ready", cmd_ready, 1);
        check("t7_rel_vlmul", vlmul, 0);
        check("t7_rel_rsp", rsp_valid, 0);
        chk_en = 1'b1;

        run_cmd(10'h008, 32'h0443, 32'h0, 8'h00, 0, 1'b0);
        check("t8_after_rst_wb", (wb_log.size() > 0) ? wb_log[0] : 5'h1F, 3);
        check("t8_after_rst_loads", loads, 1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
